spi_cmd_frontend: RTL and testbench
===================================

SPI_CMD_FRONTEND -- requirements
Module: spi_cmd_frontend

Interface
REQ-001 Parameter N, default 4, operation-code width; SHALL match the downstream execution unit's opcode width.
REQ-002 Parameter M, default 4, argument and result width.
REQ-003 Parameter F, derived as N+2*M (12 by default), command frame length in bits; not overridable.
REQ-004 i_clk  input  1  system clock; the only clock; all flops on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_sclk  input  1  SPI serial clock, asynchronous to i_clk, SPI mode 0.
REQ-007 i_cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-008 i_mosi  input  1  SPI serial data in, MSB first.
REQ-009 o_miso  output  1  SPI serial data out, MSB first.
REQ-010 o_oper  output  N  latched opcode to the execution unit.
REQ-011 o_argA, o_argB  output  M each  latched operands to the execution unit.
REQ-012 o_start  output  1  one-cycle pulse; new command presented.
REQ-013 i_result  input  M  execution-unit result.
REQ-014 i_OF, i_BF, i_PF, i_VF  input  1 each  execution-unit flags.
REQ-015 o_busy  output  1  high while a frame is in progress (cs active).
REQ-016 o_frame_err  output  1  one-cycle pulse on a short frame.

Function
REQ-017 i_sclk, i_cs_n and i_mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized signals; i_clk SHALL be at least 8x i_sclk.
REQ-018 FSM states: IDLE, SHIFT, EXEC, CAPTURE, WAIT_CS.
REQ-019 IDLE -> SHIFT on a synchronized cs falling edge; the bit counter clears and the TX register loads the response word.
REQ-020 In SHIFT, on each synchronized sclk rising edge, sample mosi into the RX shift register and increment the bit counter.
REQ-021 In SHIFT, on each synchronized sclk falling edge, shift the TX register left, filling with 0.
REQ-022 Frame bit order: oper[N-1:0], then argA[M-1:0], then argB[M-1:0].
REQ-023 SHIFT -> EXEC in the cycle after the F-th rising edge is detected.
REQ-024 In EXEC: load o_oper/o_argA/o_argB from RX and assert o_start for exactly one cycle; go to CAPTURE.
REQ-025 In CAPTURE: register the response word {i_result, i_OF, i_BF, i_PF, i_VF} (M+4 bits); go to WAIT_CS.
REQ-026 Required latency: o_start 1 cycle after F-th edge detection; response captured 1 cycle after o_start; the execution unit is combinational.
REQ-027 In WAIT_CS, further sclk edges SHALL be ignored for RX; TX keeps shifting (zeros after the response).
REQ-028 WAIT_CS -> IDLE on cs rising edge.
REQ-029 A cs rising edge in SHIFT with counter < F -> IDLE, pulse o_frame_err, do not assert o_start; o_oper/o_argA/o_argB and the response register stay unchanged.
REQ-030 o_miso SHALL equal TX[MSB] while cs is low; the first bit is valid before the first sclk rising edge; o_miso is 0 while cs is high.
REQ-031 Response pipelining: the response of frame k SHALL be shifted out during the first M+4 bits of frame k+1; the remaining bits are 0.
REQ-032 o_busy SHALL be high in SHIFT, EXEC, CAPTURE and WAIT_CS.
REQ-033 The bit counter SHALL saturate at F; frames longer than F bits SHALL not wrap or re-trigger.

Reset
REQ-034 On i_rst: FSM = IDLE; all outputs, counters, RX/TX and response registers = 0; synchronizer flops = 1 for cs and 0 for sclk and mosi.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no o_start and no o_frame_err; after release, the next cs falling edge starts a clean frame.

Verification
REQ-036 Frame 0000_0011_0101 -> o_oper=0000, o_argA=0011, o_argB=0101, o_start pulses exactly once.
REQ-037 With i_result=1000 and flags OF,BF,PF,VF=0,1,1,0 held, next frame -> o_miso bits 1000_0110 then 0000.
REQ-038 cs deasserted after 7 bits -> o_frame_err one pulse; no o_start; outputs keep their previous values.
REQ-039 20-bit frame -> single o_start after bit 12; bits 13-20 ignored.
REQ-040 i_rst asserted after bit 5 -> all outputs 0; a following full frame 1011_1010_0000 -> o_oper=1011 and a first response of 0x00.
REQ-041 Back-to-back frames with i_clk = 8x i_sclk -> each command decoded and each response returned one frame later.

Source files
------------

// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 command front end: deserialises {oper, argA, argB} frames, launches the
// execution unit, and returns the registered {result, flags} word during the next frame.
module spi_cmd_frontend #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_sclk,
    input  logic         i_cs_n,
    input  logic         i_mosi,
    output logic         o_miso,
    output logic [N-1:0] o_oper,
    output logic [M-1:0] o_argA,
    output logic [M-1:0] o_argB,
    output logic         o_start,
    input  logic [M-1:0] i_result,
    input  logic         i_OF,
    input  logic         i_BF,
    input  logic         i_PF,
    input  logic         i_VF,
    output logic         o_busy,
    output logic         o_frame_err
);

    localparam int F  = N + 2 * M;
    localparam int RW = M + 4;
    localparam int CW = $clog2(F + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SHIFT   = 3'd1;
    localparam logic [2:0] EXEC    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] WAIT_CS = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [F-1:0]  rx;
    logic [F-1:0]  tx;
    logic [F-1:0]  tx_load;
    logic [RW-1:0] resp;

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    // cs idles high, so its synchronizer and edge history reset to 1 to avoid a phantom edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], i_sclk};
            cs_sync   <= {cs_sync[0], i_cs_n};
            mosi_sync <= {mosi_sync[0], i_mosi};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign cs_rise   = cs_sync[1] & ~cs_prev;

    always_comb begin
        tx_load = '0;
        tx_load[F-1 -: RW] = resp;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            resp        <= '0;
            o_oper      <= '0;
            o_argA      <= '0;
            o_argB      <= '0;
            o_start     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_start     <= 1'b0;
            o_frame_err <= 1'b0;
            if (state != IDLE && sclk_fall) begin
                tx <= {tx[F-2:0], 1'b0};
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        tx      <= tx_load;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        o_frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        rx <= {rx[F-2:0], mosi_sync[1]};
                        if (bit_cnt < CW'(F)) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (bit_cnt == CW'(F - 1)) begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    o_oper  <= rx[F-1 -: N];
                    o_argA  <= rx[2*M-1 -: M];
                    o_argB  <= rx[M-1:0];
                    o_start <= 1'b1;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    resp  <= {i_result, i_OF, i_BF, i_PF, i_VF};
                    state <= WAIT_CS;
                end
                WAIT_CS: begin
                    // Level test also catches a cs release that landed during EXEC/CAPTURE
                    if (cs_sync[1]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);
    assign o_miso = o_busy & ~cs_sync[1] & tx[F-1];

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Scoreboard bench for spi_cmd_frontend: an SPI master task issues frames, queues hold
// expected commands, frame errors and MISO words, and a monitor process checks them.
module tb_spi_cmd_frontend;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_sclk = 1'b0;
    logic       i_cs_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso;
    logic [3:0] o_oper;
    logic [3:0] o_argA;
    logic [3:0] o_argB;
    logic       o_start;
    logic [3:0] i_result = 4'h0;
    logic       i_OF = 1'b0;
    logic       i_BF = 1'b0;
    logic       i_PF = 1'b0;
    logic       i_VF = 1'b0;
    logic       o_busy;
    logic       o_frame_err;

    int compared = 0;
    int mismatched = 0;
    int pending_err = 0;

    logic [11:0] exp_cmd[$];
    logic [31:0] exp_resp[$];
    logic [31:0] act_resp[$];

    spi_cmd_frontend #(.N(4), .M(4)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_sclk(i_sclk),
        .i_cs_n(i_cs_n),
        .i_mosi(i_mosi),
        .o_miso(o_miso),
        .o_oper(o_oper),
        .o_argA(o_argA),
        .o_argB(o_argB),
        .o_start(o_start),
        .i_result(i_result),
        .i_OF(i_OF),
        .i_BF(i_BF),
        .i_PF(i_PF),
        .i_VF(i_VF),
        .o_busy(o_busy),
        .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setResult(input logic [3:0] r, input logic [3:0] flags);
        i_result = r;
        {i_OF, i_BF, i_PF, i_VF} = flags;
    endtask

    // Mode-0 master at 8 i_clk cycles per sclk; MISO is sampled on each rising edge
    task automatic applyStimulus(input logic [31:0] bits, input int nbits,
                                 input bit release_cs, input logic [31:0] miso_exp);
        logic [31:0] got;
        got = '0;
        i_cs_n = 1'b0;
        #80;
        for (int i = nbits - 1; i >= 0; i--) begin
            i_mosi = bits[i];
            #40;
            i_sclk = 1'b1;
            got = {got[30:0], o_miso};
            if (i == nbits - 1) checkOutput("busy_in_frame", {31'd0, o_busy}, 32'd1);
            #40;
            i_sclk = 1'b0;
        end
        #80;
        if (release_cs) begin
            i_cs_n = 1'b1;
            #80;
            checkOutput("busy_after_cs", {31'd0, o_busy}, 32'd0);
        end
        exp_resp.push_back(miso_exp);
        act_resp.push_back(got);
    endtask

    task automatic sendCmd(input logic [11:0] cmd, input logic [31:0] miso_exp);
        exp_cmd.push_back(cmd);
        applyStimulus({20'd0, cmd}, 12, 1'b1, miso_exp);
    endtask

    initial begin : monitor
        logic [11:0] c;
        logic [31:0] e;
        logic [31:0] a;
        forever begin
            @(negedge i_clk);
            if (o_start) begin
                if (exp_cmd.size() == 0) begin
                    checkOutput("unexpected_start", 32'd1, 32'd0);
                end else begin
                    c = exp_cmd.pop_front();
                    checkOutput("cmd", {20'd0, o_oper, o_argA, o_argB}, {20'd0, c});
                end
            end
            if (o_frame_err) begin
                checkOutput("frame_err_expected", {31'd0, pending_err > 0}, 32'd1);
                if (pending_err > 0) pending_err--;
            end
            if (act_resp.size() > 0 && exp_resp.size() > 0) begin
                a = act_resp.pop_front();
                e = exp_resp.pop_front();
                checkOutput("miso_word", a, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : stimulus
        i_rst = 1'b1;
        #40;
        checkOutput("rst_oper", {28'd0, o_oper}, 32'd0);
        checkOutput("rst_argA", {28'd0, o_argA}, 32'd0);
        checkOutput("rst_argB", {28'd0, o_argB}, 32'd0);
        checkOutput("rst_start", {31'd0, o_start}, 32'd0);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        checkOutput("rst_miso", {31'd0, o_miso}, 32'd0);
        i_rst = 1'b0;
        #100;

        $display("[TB] basic frame and pipelined response");
        setResult(4'b1000, 4'b0110);
        sendCmd(12'h035, 32'h000);
        setResult(4'b0101, 4'b1001);
        sendCmd(12'hA69, 32'h860);

        $display("[TB] short frame");
        pending_err++;
        applyStimulus(32'h0000_0055, 7, 1'b1, 32'h2C);
        #40;
        checkOutput("short_oper", {28'd0, o_oper}, 32'hA);
        checkOutput("short_argA", {28'd0, o_argA}, 32'h6);
        checkOutput("short_argB", {28'd0, o_argB}, 32'h9);

        $display("[TB] long frame");
        setResult(4'b1111, 4'b0001);
        exp_cmd.push_back(12'h3C7);
        applyStimulus({12'd0, 12'h3C7, 8'hA5}, 20, 1'b1, 32'h59000);

        $display("[TB] reset mid-frame");
        applyStimulus(32'h0000_0016, 5, 1'b0, 32'h1E);
        i_rst = 1'b1;
        #20;
        i_cs_n = 1'b1;
        #20;
        checkOutput("abort_oper", {28'd0, o_oper}, 32'd0);
        checkOutput("abort_argA", {28'd0, o_argA}, 32'd0);
        checkOutput("abort_argB", {28'd0, o_argB}, 32'd0);
        checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;
        #100;
        setResult(4'b0011, 4'b1100);
        sendCmd(12'hBA0, 32'h000);
        checkOutput("post_rst_oper", {28'd0, o_oper}, 32'hB);

        $display("[TB] back-to-back frames");
        setResult(4'b0100, 4'b0000);
        sendCmd(12'h123, 32'h3C0);
        setResult(4'b0111, 4'b1111);
        sendCmd(12'h456, 32'h400);
        setResult(4'b0000, 4'b0000);
        sendCmd(12'h789, 32'h7F0);
        sendCmd(12'hFFF, 32'h000);

        #100;
        checkOutput("cmd_queue_drained", exp_cmd.size(), 32'd0);
        checkOutput("ferr_all_seen", pending_err, 32'd0);
        checkOutput("resp_queue_drained", act_resp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
